// File: rtl/vs_rb_pickup_unit.sv
// vs_rb_pickup_unit
// Consumer side of the result buffer. Pickup requests are queued in order.
// The head request's RB entry is read until it turns valid. Its pointer tag is
// checked, the result is handed to register writeback, and the entry is cleared.
module vs_rb_pickup_unit #(
  parameter int RESULT_BUFFER_SIZE = 8,
  parameter int REGISTER_COUNT     = 32,
  parameter int QUEUE_DEPTH        = 4,
  parameter int WAIT_LIMIT         = 255,
  localparam int RB_ID_W  = $clog2(RESULT_BUFFER_SIZE),
  localparam int REG_ID_W = $clog2(REGISTER_COUNT)
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                flush,
  input  logic                pick_en,
  input  logic [RB_ID_W-1:0]  pick_rb_idx,
  input  logic [REG_ID_W-1:0] pick_ptr_id,
  input  logic [REG_ID_W-1:0] pick_rd,
  output logic                pick_ready,
  output logic                rb_rd_en,
  output logic [RB_ID_W-1:0]  rb_rd_idx,
  input  logic [37:0]         rb_rd_entry,
  output logic                rb_clr_en,
  output logic [RB_ID_W-1:0]  rb_clr_idx,
  output logic                wb_valid,
  output logic [REG_ID_W-1:0] wb_rd,
  output logic [31:0]         wb_data,
  input  logic                wb_ready,
  output logic                timeout_err,
  output logic                tag_err,
  output logic                busy
);

  localparam int QPTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = QPTR_W + 1;
  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WB
  } state_t;

  state_t state, state_nxt;

  logic [RB_ID_W-1:0]  q_rb_idx [QUEUE_DEPTH];
  logic [REG_ID_W-1:0] q_ptr_id [QUEUE_DEPTH];
  logic [REG_ID_W-1:0] q_rd     [QUEUE_DEPTH];
  logic [QPTR_W-1:0]   wr_ptr;
  logic [QPTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]    count;

  logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
  logic                push;
  logic                pop;
  logic                load_wb;
  logic                wb_fire;

  logic [RB_ID_W-1:0]  head_rb_idx;
  logic [REG_ID_W-1:0] head_ptr_id;
  logic [REG_ID_W-1:0] head_rd;

  logic [31:0]         entry_result;
  logic                entry_valid;
  logic [4:0]          entry_ptr;

  assign entry_result = rb_rd_entry[37:6];
  assign entry_valid  = rb_rd_entry[5];
  assign entry_ptr    = rb_rd_entry[4:0];

  assign head_rb_idx = q_rb_idx[rd_ptr];
  assign head_ptr_id = q_ptr_id[rd_ptr];
  assign head_rd     = q_rd[rd_ptr];

  assign pick_ready = (count != CNT_W'(QUEUE_DEPTH));
  assign push       = pick_en && pick_ready && !flush;
  assign wb_fire    = wb_valid && wb_ready;
  assign busy       = (count != '0) || (state != IDLE);

  // Queue storage holds only payload; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rb_idx[wr_ptr] <= pick_rb_idx;
      q_ptr_id[wr_ptr] <= pick_ptr_id;
      q_rd[wr_ptr]     <= pick_rd;
    end
  end

  // Queue pointers and occupancy; a flush empties the queue outright.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + QPTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + QPTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State register and the invalid-entry wait counter.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next-state and strobe decode; flush overrides everything and emits no pulses.
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    rb_rd_en    = 1'b0;
    rb_rd_idx   = '0;
    rb_clr_en   = 1'b0;
    rb_clr_idx  = '0;
    tag_err     = 1'b0;
    timeout_err = 1'b0;
    pop         = 1'b0;
    load_wb     = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      wait_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            rb_rd_en  = 1'b1;
            rb_rd_idx = head_rb_idx;
            state_nxt = CHECK;
          end
        end
        CHECK: begin
          if (entry_valid) begin
            if (entry_ptr == 5'(head_ptr_id)) begin
              load_wb   = 1'b1;
              state_nxt = WB;
            end else begin
              tag_err   = 1'b1;
              pop       = 1'b1;
              wait_nxt  = '0;
              state_nxt = IDLE;
            end
          end else if (wait_cnt < WAIT_W'(WAIT_LIMIT)) begin
            wait_nxt  = wait_cnt + WAIT_W'(1);
            rb_rd_en  = 1'b1;
            rb_rd_idx = head_rb_idx;
          end else begin
            timeout_err = 1'b1;
            pop         = 1'b1;
            wait_nxt    = '0;
            state_nxt   = IDLE;
          end
        end
        WB: begin
          if (wb_fire) begin
            rb_clr_en  = 1'b1;
            rb_clr_idx = head_rb_idx;
            pop        = 1'b1;
            wait_nxt   = '0;
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Writeback registers stay stable from the tag match until the handshake.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (load_wb) begin
      wb_valid <= 1'b1;
      wb_rd    <= head_rd;
      wb_data  <= entry_result;
    end else if (wb_fire) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vs_rb_pickup_unit.sv
// tb_vs_rb_pickup_unit
// Random and directed pickups against a transaction-level reference model.
// The bench also plays the result buffer: each read of the head request's entry
// returns invalid until that request's chosen number of reads has elapsed.
module tb_vs_rb_pickup_unit;

  localparam int QDEPTH     = 4;
  localparam int READ_LIMIT = 256;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        flush = 1'b0;
  logic        pick_en = 1'b0;
  logic [2:0]  pick_rb_idx = '0;
  logic [4:0]  pick_ptr_id = '0;
  logic [4:0]  pick_rd = '0;
  logic        pick_ready;
  logic        rb_rd_en;
  logic [2:0]  rb_rd_idx;
  logic [37:0] rb_rd_entry = '0;
  logic        rb_clr_en;
  logic [2:0]  rb_clr_idx;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready = 1'b0;
  logic        timeout_err;
  logic        tag_err;
  logic        busy;

  vs_rb_pickup_unit dut (
    .clk(clk), .nRst(nRst), .flush(flush), .pick_en(pick_en),
    .pick_rb_idx(pick_rb_idx), .pick_ptr_id(pick_ptr_id), .pick_rd(pick_rd),
    .pick_ready(pick_ready), .rb_rd_en(rb_rd_en), .rb_rd_idx(rb_rd_idx),
    .rb_rd_entry(rb_rd_entry), .rb_clr_en(rb_clr_en), .rb_clr_idx(rb_clr_idx),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .timeout_err(timeout_err), .tag_err(tag_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // A pickup request together with the RB entry it will find.
  typedef struct {
    logic [2:0]  idx;
    logic [4:0]  ptr;
    logic [4:0]  rd;
    logic [4:0]  rb_tag;
    logic [31:0] data;
    int          delay;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        stim;
  txn_t        blank;
  logic [4:0]  hs_rd_log[$];
  logic [37:0] resp_entry = '0;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  reads = 0;
  bit  resp_pending = 0;
  bit  exp_wb = 0;
  bit  last_accepted = 0;
  int  first_rd_cyc = -1;
  int  first_wb_cyc = -1;
  int  rd_cnt = 0;
  int  wb_hs_cnt = 0;
  int  clr_cnt = 0;
  int  tag_cnt = 0;
  int  to_cnt = 0;

  // Synchronous RB read port: data of a read appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rb_rd_en) rb_rd_entry <= resp_entry;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t make_txn(input logic [2:0] idx, input logic [4:0] ptr, input logic [4:0] rd,
                                    input logic [4:0] rb_tag, input logic [31:0] data, input int delay);
    txn_t t;
    t.idx = idx; t.ptr = ptr; t.rd = rd; t.rb_tag = rb_tag; t.data = data; t.delay = delay;
    return t;
  endfunction

  function automatic txn_t random_txn();
    txn_t t;
    int   r;
    t.idx    = 3'($urandom_range(0, 7));
    t.ptr    = 5'($urandom_range(0, 31));
    t.rd     = 5'($urandom_range(0, 31));
    t.data   = $urandom();
    t.rb_tag = ($urandom_range(0, 99) < 80) ? t.ptr : t.ptr ^ 5'($urandom_range(1, 31));
    r        = $urandom_range(0, 99);
    t.delay  = (r < 4) ? READ_LIMIT + $urandom_range(0, 3) : $urandom_range(0, 6);
    return t;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    exp_wb       = 0;
    reads        = 0;
    resp_pending = 0;
  endtask

  // Compares one cycle of DUT outputs with the model, then advances the model
  // across the coming clock edge.
  task automatic check_cycle();
    bit   exp_tag, exp_to, exp_reread, goto_wb;
    int   size_before;
    txn_t f;
    logic entry_valid;
    exp_tag = 0; exp_to = 0; exp_reread = 0; goto_wb = 0;
    size_before = exp_q.size();
    f = blank;
    if (size_before != 0) f = exp_q[0];

    if (resp_pending && !flush && size_before != 0) begin
      if (reads > f.delay) begin
        if (f.rb_tag == f.ptr) goto_wb = 1;
        else exp_tag = 1;
      end else if (reads < READ_LIMIT) exp_reread = 1;
      else exp_to = 1;
    end

    check_output("pick_ready", pick_ready, size_before < QDEPTH);
    check_output("busy", busy, size_before != 0);
    check_output("tag_err", tag_err, exp_tag);
    check_output("timeout_err", timeout_err, exp_to);
    if (exp_reread) check_output("reread", rb_rd_en, 1);
    check_output("wb_valid", wb_valid, exp_wb);
    if (wb_valid && exp_wb) begin
      check_output("wb_rd", wb_rd, f.rd);
      check_output("wb_data", wb_data, f.data);
    end
    check_output("rb_clr_en", rb_clr_en, exp_wb && wb_ready && !flush);
    if (rb_clr_en && exp_wb) check_output("rb_clr_idx", rb_clr_idx, f.idx);

    if (rb_clr_en) clr_cnt++;
    if (tag_err) tag_cnt++;
    if (timeout_err) to_cnt++;
    if (wb_valid && first_wb_cyc < 0) first_wb_cyc = cyc;
    if (wb_valid && wb_ready && !flush) begin
      wb_hs_cnt++;
      hs_rd_log.push_back(wb_rd);
    end
    if (rb_rd_en) begin
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      check_output("rd_has_req", (size_before != 0) && !exp_wb, 1);
      if (size_before != 0) begin
        check_output("rb_rd_idx", rb_rd_idx, f.idx);
        reads++;
        entry_valid = (reads > f.delay);
        resp_entry  = {entry_valid ? f.data : $urandom(), entry_valid, f.rb_tag};
      end
    end

    if (flush) begin
      clear_model();
    end else begin
      resp_pending = rb_rd_en;
      if ((exp_tag || exp_to) && size_before != 0) begin
        exp_q.delete(0);
        reads = 0;
      end else if (exp_wb && wb_ready) begin
        exp_q.delete(0);
        exp_wb = 0;
        reads  = 0;
      end
      if (goto_wb) exp_wb = 1;
    end
    last_accepted = pick_en && (size_before < QDEPTH) && !flush;
    if (last_accepted) exp_q.push_back(stim);
  endtask

  task automatic apply_stimulus(input bit pen, input txn_t t, input bit wbr, input bit fl);
    @(negedge clk);
    pick_en     = pen;
    pick_rb_idx = t.idx;
    pick_ptr_id = t.ptr;
    pick_rd     = t.rd;
    wb_ready    = wbr;
    flush       = fl;
    stim        = t;
    cyc++;
    #1;
    check_cycle();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_wb) && n < budget) begin
      apply_stimulus(0, blank, 1, 0);
      n++;
    end
    check_output("drain_done", exp_q.size(), 0);
    apply_stimulus(0, blank, 1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_pick_ready"}, pick_ready, 1);
    check_output({tag, "_outputs"},
                 {rb_rd_en, rb_rd_idx, rb_clr_en, rb_clr_idx, wb_valid, wb_rd, wb_data,
                  timeout_err, tag_err, busy}, 0);
  endtask

  initial begin
    int base_wb, base_rd, base_to, base_tag, base_clr, n;
    blank = make_txn(0, 0, 0, 0, 0, 0);

    // Power-on reset state.
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    nRst = 1'b1;
    clear_model();

    // Single pickup into an idle unit with the entry already valid.
    first_rd_cyc = -1; first_wb_cyc = -1; base_clr = clr_cnt;
    apply_stimulus(1, make_txn(3, 5, 7, 5, 32'hDEADBEEF, 0), 1, 0);
    n = cyc;
    repeat (5) apply_stimulus(0, blank, 1, 0);
    check_output("t1_rd_latency", first_rd_cyc - n, 1);
    check_output("t1_wb_latency", first_wb_cyc - n, 3);
    check_output("t1_clr", clr_cnt - base_clr, 1);
    check_output("t1_busy", busy, 0);

    // Entry turns valid after ten invalid reads.
    base_rd = rd_cnt; base_wb = wb_hs_cnt; base_to = to_cnt;
    apply_stimulus(1, make_txn(2, 3, 9, 3, 32'h1234_5678, 10), 1, 0);
    drain(60);
    check_output("t2_reads", rd_cnt - base_rd, 11);
    check_output("t2_wb", wb_hs_cnt - base_wb, 1);
    check_output("t2_timeout", to_cnt - base_to, 0);

    // Entry never turns valid.
    base_rd = rd_cnt; base_wb = wb_hs_cnt; base_to = to_cnt; base_clr = clr_cnt;
    apply_stimulus(1, make_txn(1, 4, 2, 4, 32'h0BAD_F00D, 1000), 1, 0);
    drain(400);
    check_output("t3_reads", rd_cnt - base_rd, READ_LIMIT);
    check_output("t3_timeout", to_cnt - base_to, 1);
    check_output("t3_wb", wb_hs_cnt - base_wb, 0);
    check_output("t3_clr", clr_cnt - base_clr, 0);

    // Tag mismatch drops the head; the next request still completes.
    base_tag = tag_cnt; base_wb = wb_hs_cnt;
    apply_stimulus(1, make_txn(4, 6, 10, 9, 32'hAAAA_0001, 0), 1, 0);
    apply_stimulus(1, make_txn(5, 8, 11, 8, 32'hBBBB_0002, 0), 1, 0);
    drain(40);
    check_output("t4_tag", tag_cnt - base_tag, 1);
    check_output("t4_wb", wb_hs_cnt - base_wb, 1);

    // Fill the queue while writeback is stalled, then release.
    base_wb = wb_hs_cnt;
    hs_rd_log.delete();
    for (int i = 0; i < 4; i++)
      apply_stimulus(1, make_txn(3'(i), 5'(i), 5'(i + 1), 5'(i), 32'hC000_0000 + i, 0), 0, 0);
    apply_stimulus(1, make_txn(6, 4, 5, 4, 32'hC000_0004, 0), 0, 0);
    check_output("t5_full", pick_ready, 0);
    check_output("t5_not_taken", last_accepted, 0);
    repeat (4) apply_stimulus(1, make_txn(6, 4, 5, 4, 32'hC000_0004, 0), 0, 0);
    n = 0;
    do begin
      apply_stimulus(1, make_txn(6, 4, 5, 4, 32'hC000_0004, 0), 1, 0);
      n++;
    end while (!last_accepted && n < 30);
    check_output("t5_fifth_taken", last_accepted, 1);
    drain(60);
    check_output("t5_wb", wb_hs_cnt - base_wb, 5);
    for (int i = 0; i < 5; i++)
      check_output("t5_order", (i < hs_rd_log.size()) ? hs_rd_log[i] : 5'h1F, 5'(i + 1));

    // Flush while in writeback with three queued, plus a simultaneous pick.
    for (int i = 0; i < 3; i++)
      apply_stimulus(1, make_txn(3'(i + 2), 5'(i), 5'(i + 20), 5'(i), 32'hF000_0000 + i, 0), 0, 0);
    n = 0;
    while (!wb_valid && n < 20) begin
      apply_stimulus(0, blank, 0, 0);
      n++;
    end
    check_output("t6_in_wb", wb_valid, 1);
    base_clr = clr_cnt;
    apply_stimulus(1, make_txn(7, 1, 1, 1, 32'h7777_7777, 0), 1, 1);
    apply_stimulus(0, blank, 1, 0);
    check_output("t6_wb_valid", wb_valid, 0);
    check_output("t6_busy", busy, 0);
    check_output("t6_clr", clr_cnt - base_clr, 0);
    apply_stimulus(0, blank, 1, 0);

    // Asynchronous reset while waiting on an invalid entry.
    apply_stimulus(1, make_txn(0, 2, 3, 2, 32'h5555_AAAA, 50), 1, 0);
    repeat (4) apply_stimulus(0, blank, 1, 0);
    check_output("t6_in_check", busy, 1);
    @(negedge clk);
    #2;
    nRst = 1'b0;
    pick_en = 1'b0;
    #1;
    check_reset_outputs("midreset");
    clear_model();
    @(negedge clk);
    nRst = 1'b1;

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      apply_stimulus($urandom_range(0, 1), random_txn(), $urandom_range(0, 9) < 7,
                     $urandom_range(0, 99) < 3);
    end
    drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
